// File: rtl/mc_control_sequencer_if.sv
// Control and handshake bundle between the control sequencer and the datapath/memory.
// The master side is the sequencer; the slave side is the datapath/memory.
interface mc_control_sequencer_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  aluctrl;
  logic        memtoreg;
  logic        alusrc;
  logic        regdst;
  logic        regwrite;
  logic        memwrite;
  logic        mem_req;
  logic        pcsrc;
  logic        jump;
  logic        pc_en;
  logic        ir_en;
  logic        trap;
  logic [15:0] retired;

  modport master (
    input  instr, zero, mem_ready,
    output aluctrl, memtoreg, alusrc, regdst, regwrite, memwrite, mem_req,
    output pcsrc, jump, pc_en, ir_en, trap, retired
  );

  modport slave (
    output instr, zero, mem_ready,
    input  aluctrl, memtoreg, alusrc, regdst, regwrite, memwrite, mem_req,
    input  pcsrc, jump, pc_en, ir_en, trap, retired
  );
endinterface

// File: rtl/mc_control_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state.
// Level controls come from decode registers captured on the FETCH->DECODE edge; strobes
// are decoded from the current state (and zero/mem_ready where the same-cycle response
// is needed), and all of them are forced low while rst is high.
module mc_control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst,
  mc_control_sequencer_if.master bus
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [5:0]  funct_q, funct_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] retired_q, retired_d;

  logic       dec_valid, dec_alusrc, dec_regdst, dec_memtoreg, dec_jump;
  logic [2:0] dec_alu;
  logic       is_lw, is_sw, is_beq, is_j;

  logic       levels_on, in_exec, in_mem, in_wb;
  logic [2:0] aluctrl;
  logic       memtoreg, alusrc, regdst, regwrite, memwrite, mem_req;
  logic       pcsrc, jump, pc_en, ir_en, trap;

  // Only opcode and funct matter to the sequencer.
  logic unused_instr;
  assign unused_instr = ^bus.instr[25:6];

  // Decode the registered opcode/funct into level controls and a legality flag.
  always_comb begin
    dec_valid    = 1'b1;
    dec_alu      = 3'b000;
    dec_alusrc   = 1'b0;
    dec_regdst   = 1'b0;
    dec_memtoreg = 1'b0;
    dec_jump     = 1'b0;
    case (op_q)
      OpRtype: begin
        dec_regdst = 1'b1;
        case (funct_q)
          6'b100000: dec_alu = 3'b010;
          6'b100010: dec_alu = 3'b110;
          6'b100100: dec_alu = 3'b000;
          6'b100101: dec_alu = 3'b001;
          6'b101010: dec_alu = 3'b111;
          default: begin
            dec_valid  = 1'b0;
            dec_regdst = 1'b0;
          end
        endcase
      end
      OpLw: begin
        dec_alu      = 3'b010;
        dec_alusrc   = 1'b1;
        dec_memtoreg = 1'b1;
      end
      OpSw: begin
        dec_alu    = 3'b010;
        dec_alusrc = 1'b1;
      end
      OpAddi: begin
        dec_alu    = 3'b010;
        dec_alusrc = 1'b1;
      end
      OpBeq:   dec_alu  = 3'b110;
      OpJ:     dec_jump = 1'b1;
      default: dec_valid = 1'b0;
    endcase
  end

  assign is_lw  = (op_q == OpLw);
  assign is_sw  = (op_q == OpSw);
  assign is_beq = (op_q == OpBeq);
  assign is_j   = (op_q == OpJ);

  // Next-state, decode capture, MEM timeout counter and retire counter.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    cnt_d     = cnt_q;
    retired_d = retired_q + {15'd0, pc_en};
    case (state_q)
      StFetch: begin
        op_d    = bus.instr[31:26];
        funct_d = bus.instr[5:0];
        state_d = StDecode;
      end
      StDecode: state_d = dec_valid ? StExec : StTrap;
      StExec: begin
        cnt_d = 8'd0;
        if (is_beq || is_j)     state_d = StFetch;
        else if (is_lw || is_sw) state_d = StMem;
        else                     state_d = StWb;
      end
      StMem: begin
        if (bus.mem_ready) begin
          cnt_d   = 8'd0;
          state_d = is_sw ? StFetch : StWb;
        end else begin
          cnt_d = cnt_q + 8'd1;
          // Last allowed wait cycle just passed without ready.
          if (cnt_q == TimeoutLast) state_d = StTrap;
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      cnt_q     <= 8'd0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  // Output decode; rst gates everything so strobes drop as soon as reset rises.
  always_comb begin
    levels_on = !rst && (state_q inside {StDecode, StExec, StMem, StWb});
    in_exec   = !rst && (state_q == StExec);
    in_mem    = !rst && (state_q == StMem);
    in_wb     = !rst && (state_q == StWb);
    aluctrl   = levels_on ? dec_alu : 3'b000;
    alusrc    = levels_on && dec_alusrc;
    regdst    = levels_on && dec_regdst;
    memtoreg  = levels_on && dec_memtoreg;
    jump      = levels_on && dec_jump;
    ir_en     = !rst && (state_q == StFetch);
    mem_req   = in_mem;
    memwrite  = in_mem && is_sw;
    pcsrc     = in_exec && is_beq && bus.zero;
    pc_en     = (in_exec && (is_beq || is_j)) || (in_mem && is_sw && bus.mem_ready) || in_wb;
    regwrite  = in_wb;
    trap      = !rst && (state_q == StTrap);
  end

  assign bus.aluctrl  = aluctrl;
  assign bus.memtoreg = memtoreg;
  assign bus.alusrc   = alusrc;
  assign bus.regdst   = regdst;
  assign bus.regwrite = regwrite;
  assign bus.memwrite = memwrite;
  assign bus.mem_req  = mem_req;
  assign bus.pcsrc    = pcsrc;
  assign bus.jump     = jump;
  assign bus.pc_en    = pc_en;
  assign bus.ir_en    = ir_en;
  assign bus.trap     = trap;
  assign bus.retired  = retired_q;

endmodule
